// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the debounce bank.
// Defaults for a 100 MHz clock.
package debounce_pkg;

   localparam int CNT_MAX_SIM   = 4095;
   localparam int CNT_MAX_BOARD = 1_000_000;
   localparam int REPEAT_DELAY_DEF  = 50_000_000;
   localparam int REPEAT_PERIOD_DEF = 10_000_000;

   function automatic int width_of(input int v);
      return (v < 2) ? 1 : $clog2(v + 1);
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, stability counter, strobes.
// Auto-repeat logic is present only when HOLD_REPEAT_EN is defined.
module debounce_ch
   import debounce_pkg::*;
#(
   parameter int CNT_MAX       = CNT_MAX_SIM,
   parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic state,
   output logic rise,
   output logic fall,
   output logic rep
);

   localparam int CNT_W = width_of(CNT_MAX);

   logic             sync0;
   logic             sync1;
   logic [CNT_W-1:0] cnt;
   logic             idle;
   logic             flip;

   assign idle = (state == sync1);
   assign flip = !idle && (cnt == CNT_W'(CNT_MAX));

   // two-flop synchroniser for the asynchronous raw input
   always_ff @(posedge clk) begin
      if (rst) begin
         sync0 <= 1'b0;
         sync1 <= 1'b0;
      end else begin
         sync0 <= raw;
         sync1 <= sync0;
      end
   end

   // stability counter; level flips after CNT_MAX+1 mismatched cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         state <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= flip && !state;
         fall <= flip && state;
         if (idle || flip)
            cnt <= '0;
         else
            cnt <= cnt + CNT_W'(1);
         if (flip)
            state <= ~state;
      end
   end

`ifdef HOLD_REPEAT_EN
   localparam int REP_W = width_of(max_of(REPEAT_DELAY, REPEAT_PERIOD));

   logic [REP_W-1:0] rep_cnt;
   logic [REP_W-1:0] rep_nxt;
   logic [REP_W-1:0] rep_lim;
   logic             rep_run;
   logic             rep_hit;

   assign rep_nxt = rep_cnt + REP_W'(1);
   assign rep_lim = rep_run ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY);
   assign rep_hit = (rep_nxt == rep_lim);

   // hold timer: first strobe after the delay, then one per period
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt <= '0;
         rep_run <= 1'b0;
         rep     <= 1'b0;
      end else if (!state || flip) begin
         rep_cnt <= '0;
         rep_run <= 1'b0;
         rep     <= 1'b0;
      end else if (rep_hit) begin
         rep_cnt <= '0;
         rep_run <= 1'b1;
         rep     <= 1'b1;
      end else begin
         rep_cnt <= rep_nxt;
         rep     <= 1'b0;
      end
   end
`else
   assign rep = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer with per-channel input inversion.
// Define HOLD_REPEAT_EN to enable the held-button repeat strobe.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int              N_CH          = 4,
   parameter int              CNT_MAX       = CNT_MAX_SIM,
   parameter logic [N_CH-1:0] INV_MASK      = '0,
   parameter int              REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int              REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_state,
   output logic [N_CH-1:0] btn_rise,
   output logic [N_CH-1:0] btn_fall,
   output logic [N_CH-1:0] btn_rep
);

   logic [N_CH-1:0] raw;

   assign raw = btn_in ^ INV_MASK;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_ch #(
         .CNT_MAX       (CNT_MAX),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .raw   (raw[i]),
         .state (btn_state[i]),
         .rise  (btn_rise[i]),
         .fall  (btn_fall[i]),
         .rep   (btn_rep[i])
      );
   end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: CNT_MAX=4, two channels,
// channel 1 active-low. Repeat checks follow HOLD_REPEAT_EN.
module tb_debounce_bank;

   logic       clk;
   logic       rst;
   logic [1:0] btn_in;
   logic [1:0] btn_state;
   logic [1:0] btn_rise;
   logic [1:0] btn_fall;
   logic [1:0] btn_rep;

   int total;
   int bad;

   typedef struct {
      logic [1:0] in;
      int         n;
      logic [1:0] st;
      logic [1:0] ri;
      logic [1:0] fa;
   } vec_t;

   vec_t tbl[$];

`ifdef HOLD_REPEAT_EN
   localparam bit REP_ON = 1'b1;
`else
   localparam bit REP_ON = 1'b0;
`endif

   debounce_bank #(
      .N_CH          (2),
      .CNT_MAX       (4),
      .INV_MASK      (2'b10),
      .REPEAT_DELAY  (10),
      .REPEAT_PERIOD (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (btn_in),
      .btn_state (btn_state),
      .btn_rise  (btn_rise),
      .btn_fall  (btn_fall),
      .btn_rep   (btn_rep)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [1:0] st,
                        input logic [1:0] ri, input logic [1:0] fa);
      logic [7:0] got;
      logic [7:0] exp;
      got = {btn_state, btn_rise, btn_fall, btn_rep};
      exp = {st, ri, fa, 2'b00};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got st/ri/fa/rep=%b expected %b", nm, got, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] in, input int n,
                               input logic [1:0] st, input logic [1:0] ri,
                               input logic [1:0] fa);
      vec_t v;
      v.in = in;
      v.n  = n;
      v.st = st;
      v.ri = ri;
      v.fa = fa;
      return v;
   endfunction

   initial begin
      total = 0;
      bad   = 0;

      // btn_in[1]=1 is idle for the active-low channel
      tbl.push_back(mk(2'b11, 6, 2'b00, 2'b00, 2'b00)); // ch0 press, E5
      tbl.push_back(mk(2'b11, 1, 2'b01, 2'b01, 2'b00)); // E6 rise
      tbl.push_back(mk(2'b11, 1, 2'b01, 2'b00, 2'b00)); // strobe one cycle
      tbl.push_back(mk(2'b10, 6, 2'b01, 2'b00, 2'b00)); // release, E5
      tbl.push_back(mk(2'b10, 1, 2'b00, 2'b00, 2'b01)); // E6 fall
      tbl.push_back(mk(2'b10, 1, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mk(2'b11, 4, 2'b00, 2'b00, 2'b00)); // 4-cycle glitch
      tbl.push_back(mk(2'b10, 3, 2'b00, 2'b00, 2'b00)); // would flip at E6
      tbl.push_back(mk(2'b10, 10, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mk(2'b11, 6, 2'b00, 2'b00, 2'b00)); // 7-cycle pulse
      tbl.push_back(mk(2'b11, 1, 2'b01, 2'b01, 2'b00));
      tbl.push_back(mk(2'b10, 6, 2'b01, 2'b00, 2'b00)); // fall 7 edges on
      tbl.push_back(mk(2'b10, 1, 2'b00, 2'b00, 2'b01));
      tbl.push_back(mk(2'b10, 5, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mk(2'b01, 6, 2'b00, 2'b00, 2'b00)); // both press
      tbl.push_back(mk(2'b01, 1, 2'b11, 2'b11, 2'b00));
      tbl.push_back(mk(2'b01, 1, 2'b11, 2'b00, 2'b00));
      tbl.push_back(mk(2'b10, 6, 2'b11, 2'b00, 2'b00)); // both release
      tbl.push_back(mk(2'b10, 1, 2'b00, 2'b00, 2'b11));
      tbl.push_back(mk(2'b10, 3, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mk(2'b00, 6, 2'b00, 2'b00, 2'b00)); // ch1 alone
      tbl.push_back(mk(2'b00, 1, 2'b10, 2'b10, 2'b00));
      tbl.push_back(mk(2'b10, 6, 2'b10, 2'b00, 2'b00));
      tbl.push_back(mk(2'b10, 1, 2'b00, 2'b00, 2'b10));
      tbl.push_back(mk(2'b10, 3, 2'b00, 2'b00, 2'b00));

      rst    = 1'b1;
      btn_in = 2'b10;
      for (int i = 0; i < 3; i++) tick();
      check("reset", 2'b00, 2'b00, 2'b00);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_after_reset", 2'b00, 2'b00, 2'b00);
      end

      for (int v = 0; v < tbl.size(); v++) begin
         btn_in = tbl[v].in;
         for (int k = 0; k < tbl[v].n; k++) tick();
         check($sformatf("vec%0d", v), tbl[v].st, tbl[v].ri, tbl[v].fa);
      end

      // reset while ch0 count is 3 (E0..E4 seen), input stays high
      btn_in = 2'b11;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      check("mid_reset", 2'b00, 2'b00, 2'b00);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("post_reset_e6", 2'b00, 2'b00, 2'b00);
      tick();
      check("post_reset_rise", 2'b01, 2'b01, 2'b00);
      btn_in = 2'b10;
      for (int i = 0; i < 7; i++) tick();
      check("post_reset_fall", 2'b00, 2'b00, 2'b01);
      for (int i = 0; i < 5; i++) tick();

      // long hold: rise, then repeats at +10, +14, ...; the fall at
      // +50 coincides with a due repeat, which must be suppressed
      btn_in = 2'b11;
      for (int i = 0; i < 7; i++) tick();
      check("hold_rise", 2'b01, 2'b01, 2'b00);
      for (int k = 1; k <= 70; k++) begin
         logic exp_rep;
         logic exp_st;
         logic exp_fa;
         tick();
         exp_rep = REP_ON && k >= 10 && k < 50 && ((k - 10) % 4 == 0);
         exp_st  = (k < 50);
         exp_fa  = (k == 50);
         total++;
         if ({btn_state[0], btn_fall[0], btn_rep[0], btn_rise[0]} !==
             {exp_st, exp_fa, exp_rep, 1'b0}) begin
            bad++;
            $display("FAIL hold_k%0d: got st/fa/rep/ri=%b%b%b%b expected %b%b%b0",
                     k, btn_state[0], btn_fall[0], btn_rep[0], btn_rise[0],
                     exp_st, exp_fa, exp_rep);
         end
         if (k == 43) btn_in = 2'b10;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
